// File: rtl/reg_bank_dump.sv
// ----------------------------------------------------------------------------
// reg_bank_dump
//
// Row store for the register controller's write stream, plus a dump engine.
// When the controller's done level rises, the store window (DUMP_LEN rows
// starting at DUMP_BASE) is streamed out one row per beat over a
// valid/ready port. An asynchronous debug read port exposes any row.
//
// Upstream drives its inputs on negedge clk; everything here is sampled on
// posedge clk.
//
// Ports
//   clk              in   1       single clock, posedge
//   rst_n            in   1       asynchronous active-low reset
//   writemem         in   1       row write enable from the controller
//   rowaddr          in   ADDR_W  row written when writemem is high
//   wdata            in   DATA_W  row write data
//   state_ctrl_done  in   1       controller done level; a rising edge starts a dump
//   rd_addr          in   ADDR_W  debug read address
//   rd_data          out  DATA_W  row[rd_addr], combinational, no write bypass
//   dump_data        out  DATA_W  registered dump beat
//   dump_valid       out  1       dump beat valid
//   dump_ready       in   1       consumer accepts the current beat
//   dump_last        out  1       high with the final beat of the window
//   busy             out  1       dump in progress
//   dump_hazard      out  1       sticky: a write hit a window row during a dump
//   trig_overrun     out  1       sticky: done rose while a dump was in progress
//
// state  | meaning
// -------+------------------------------------------------------------------
// S_IDLE | no dump running; waiting for a done rising edge
// S_DUMP | presenting window rows; advancing one row per accepted beat
// ----------------------------------------------------------------------------
module reg_bank_dump #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 4,
    parameter logic [ADDR_W-1:0] DUMP_BASE = 4'b1000,
    parameter int                DUMP_LEN  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              writemem,
    input  logic [ADDR_W-1:0] rowaddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              state_ctrl_done,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic              dump_last,
    output logic              busy,
    output logic              dump_hazard,
    output logic              trig_overrun
);

    localparam int ROWS   = 2 ** ADDR_W;
    localparam int BEAT_W = $clog2(DUMP_LEN) + 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT     = BEAT_W'(DUMP_LEN - 1);
    localparam logic              FIRST_IS_LAST = (DUMP_LEN == 1);

    // Window bounds carry one extra bit so a window ending on the last row
    // compares correctly without wrapping.
    localparam logic [ADDR_W:0] WIN_LO = {1'b0, DUMP_BASE};
    localparam logic [ADDR_W:0] WIN_HI = WIN_LO + (ADDR_W + 1)'(DUMP_LEN - 1);

    typedef enum logic {
        S_IDLE,
        S_DUMP
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  mem [ROWS];
    logic               done_q;
    logic [BEAT_W-1:0]  beat;

    logic               done_rise;
    logic               handshake;
    logic               last_beat;
    logic               win_hit;
    logic [BEAT_W-1:0]  beat_inc;
    logic [ADDR_W-1:0]  next_row;

    assign done_rise = state_ctrl_done & ~done_q;
    assign handshake = dump_valid & dump_ready;
    assign last_beat = (beat == LAST_BEAT);
    assign beat_inc  = beat + BEAT_W'(1);
    // Row index wraps modulo the bank size.
    assign next_row  = DUMP_BASE + ADDR_W'(beat_inc);
    assign win_hit   = ({1'b0, rowaddr} >= WIN_LO) && ({1'b0, rowaddr} <= WIN_HI);

    assign rd_data   = mem[rd_addr];
    assign busy      = (state == S_DUMP);

    // Writes are never stalled by a dump; a dump load on the same edge as a
    // write to that row sees the pre-write contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROWS; i++) begin
                mem[i] <= '0;
            end
        end else if (writemem) begin
            mem[rowaddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            done_q       <= 1'b0;
            beat         <= '0;
            dump_data    <= '0;
            dump_valid   <= 1'b0;
            dump_last    <= 1'b0;
            dump_hazard  <= 1'b0;
            trig_overrun <= 1'b0;
        end else begin
            done_q <= state_ctrl_done;
            case (state)
                S_IDLE: begin
                    if (done_rise) begin
                        state        <= S_DUMP;
                        beat         <= '0;
                        dump_data    <= mem[DUMP_BASE];
                        dump_valid   <= 1'b1;
                        dump_last    <= FIRST_IS_LAST;
                        dump_hazard  <= 1'b0;
                        trig_overrun <= 1'b0;
                    end
                end
                S_DUMP: begin
                    // A held beat keeps its value; later rows pick up new
                    // contents when they are loaded.
                    if (writemem && win_hit) begin
                        dump_hazard <= 1'b1;
                    end
                    if (done_rise) begin
                        trig_overrun <= 1'b1;
                    end
                    if (handshake) begin
                        if (last_beat) begin
                            state      <= S_IDLE;
                            dump_valid <= 1'b0;
                            dump_last  <= 1'b0;
                        end else begin
                            beat      <= beat_inc;
                            dump_data <= mem[next_row];
                            dump_last <= (beat_inc == LAST_BEAT);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_dump.sv
// ----------------------------------------------------------------------------
// tb_reg_bank_dump
//
// Directed scenarios followed by a randomized phase. A reference model runs
// just before each rising edge: it keeps its own copy of the rows, decides
// which window row should be on the dump port, and queues every beat it
// expects. A separate monitor pops that queue on each accepted beat.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reg_bank_dump;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int BASE   = 8;
    localparam int LEN    = 4;

    logic              clk;
    logic              rst_n;
    logic              writemem;
    logic [ADDR_W-1:0] rowaddr;
    logic [DATA_W-1:0] wdata;
    logic              state_ctrl_done;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] dump_data;
    logic              dump_valid;
    logic              dump_ready;
    logic              dump_last;
    logic              busy;
    logic              dump_hazard;
    logic              trig_overrun;

    reg_bank_dump #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DUMP_BASE(4'b1000),
        .DUMP_LEN (LEN)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .writemem       (writemem),
        .rowaddr        (rowaddr),
        .wdata          (wdata),
        .state_ctrl_done(state_ctrl_done),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .dump_data      (dump_data),
        .dump_valid     (dump_valid),
        .dump_ready     (dump_ready),
        .dump_last      (dump_last),
        .busy           (busy),
        .dump_hazard    (dump_hazard),
        .trig_overrun   (trig_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              l;
    } beat_t;

    beat_t             exp_q[$];
    logic [DATA_W-1:0] mem_m [16];
    bit                m_active;
    int                m_idx;
    logic [DATA_W-1:0] m_cur;
    bit                m_haz;
    bit                m_ovr;
    bit                m_done_prev;

    task automatic present_row(input int idx);
        beat_t b;
        m_idx = idx;
        m_cur = mem_m[4'(BASE + idx)];
        b.d   = m_cur;
        b.l   = (idx == LEN - 1);
        exp_q.push_back(b);
    endtask

    always begin : model
        bit rise;
        @(negedge clk);
        #3;
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem_m[i] = '0;
            m_active    = 1'b0;
            m_idx       = 0;
            m_cur       = '0;
            m_haz       = 1'b0;
            m_ovr       = 1'b0;
            m_done_prev = 1'b0;
            exp_q.delete();
        end else begin
            chk("busy", 32'(busy), 32'(m_active));
            chk("dump_valid", 32'(dump_valid), 32'(m_active));
            if (m_active) chk("held_data", 32'(dump_data), 32'(m_cur));
            chk("dump_hazard", 32'(dump_hazard), 32'(m_haz));
            chk("trig_overrun", 32'(trig_overrun), 32'(m_ovr));
            chk("rd_data", 32'(rd_data), 32'(mem_m[rd_addr]));

            rise = state_ctrl_done && !m_done_prev;
            if (m_active) begin
                if (writemem && int'(rowaddr) >= BASE && int'(rowaddr) < BASE + LEN) m_haz = 1'b1;
                if (rise) m_ovr = 1'b1;
                if (dump_ready) begin
                    if (m_idx == LEN - 1) m_active = 1'b0;
                    else present_row(m_idx + 1);
                end
            end else if (rise) begin
                m_active = 1'b1;
                m_haz    = 1'b0;
                m_ovr    = 1'b0;
                present_row(0);
            end
            if (writemem) mem_m[rowaddr] = wdata;
            m_done_prev = state_ctrl_done;
        end
    end

    // ---------------- monitor ----------------
    always begin : monitor
        beat_t e;
        @(negedge clk);
        #4;
        if (rst_n && dump_valid && dump_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 32'(dump_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", 32'(dump_data), 32'(e.d));
                chk("beat_last", 32'(dump_last), 32'(e.l));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wr(input int row, input logic [DATA_W-1:0] val);
        writemem = 1'b1;
        rowaddr  = 4'(row);
        wdata    = val;
        @(negedge clk);
        writemem = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int k = 0;
        while (busy && k < max_cycles) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic mid_cycle_reset_checks(input string tag);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk({tag, "_valid"}, 32'(dump_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_data"}, 32'(dump_data), 32'd0);
        chk({tag, "_last"}, 32'(dump_last), 32'd0);
        chk({tag, "_hazard"}, 32'(dump_hazard), 32'd0);
        chk({tag, "_overrun"}, 32'(trig_overrun), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst_n           = 1'b0;
        writemem        = 1'b0;
        rowaddr         = '0;
        wdata           = '0;
        state_ctrl_done = 1'b0;
        rd_addr         = '0;
        dump_ready      = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(2);

        // T1: fill some rows, start a dump, then reset between edges.
        wr(8, 16'h1234);
        wr(2, 16'h5A5A);
        state_ctrl_done = 1'b1;
        cyc(2);
        mid_cycle_reset_checks("t1_rst");
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #1;
            chk("t1_rst_rd_data", 32'(rd_data), 32'd0);
        end
        state_ctrl_done = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        // T2: store rows 8..11, dump with ready held high.
        for (int r = 8; r < 12; r++) wr(r, 16'(r));
        rd_addr         = 4'd10;
        dump_ready      = 1'b1;
        state_ctrl_done = 1'b1;
        cyc(1);
        wait_idle(20);
        state_ctrl_done = 1'b0;
        cyc(2);

        // T3: backpressure on the second beat for three cycles.
        state_ctrl_done = 1'b1;
        dump_ready      = 1'b1;
        cyc(2);
        dump_ready = 1'b0;
        cyc(3);
        dump_ready = 1'b1;
        wait_idle(20);
        state_ctrl_done = 1'b0;
        cyc(2);

        // T4: window write while the first beat is held, then an out-of-window write.
        dump_ready      = 1'b0;
        state_ctrl_done = 1'b1;
        cyc(1);
        wr(9, 16'hBEEF);
        dump_ready = 1'b1;
        wait_idle(20);
        state_ctrl_done = 1'b0;
        cyc(1);
        dump_ready      = 1'b0;
        state_ctrl_done = 1'b1;
        cyc(1);
        wr(3, 16'hC0DE);
        dump_ready = 1'b1;
        wait_idle(20);
        state_ctrl_done = 1'b0;
        cyc(2);

        // T5: done re-raised mid dump, then held high, then a clean retrigger.
        dump_ready      = 1'b0;
        state_ctrl_done = 1'b1;
        cyc(1);
        state_ctrl_done = 1'b0;
        cyc(1);
        state_ctrl_done = 1'b1;
        cyc(1);
        dump_ready = 1'b1;
        wait_idle(20);
        cyc(4);
        state_ctrl_done = 1'b0;
        cyc(1);
        state_ctrl_done = 1'b1;
        cyc(1);
        wait_idle(20);
        state_ctrl_done = 1'b0;
        cyc(2);

        // T6: reset while the second beat is on the port.
        state_ctrl_done = 1'b1;
        dump_ready      = 1'b1;
        cyc(2);
        dump_ready = 1'b0;
        mid_cycle_reset_checks("t6_rst");
        state_ctrl_done = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
        state_ctrl_done = 1'b1;
        dump_ready      = 1'b1;
        cyc(1);
        wait_idle(20);
        state_ctrl_done = 1'b0;
        cyc(2);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            writemem   = 1'($urandom_range(0, 1));
            rowaddr    = 4'($urandom_range(0, 15));
            wdata      = 16'($urandom);
            rd_addr    = 4'($urandom_range(0, 15));
            dump_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) state_ctrl_done = ~state_ctrl_done;
            @(negedge clk);
        end

        writemem        = 1'b0;
        state_ctrl_done = 1'b0;
        dump_ready      = 1'b1;
        wait_idle(40);
        cyc(3);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
